// File: rtl/mgt_01_mul_arbiter_pkg.sv
// Shared constants and types for the multiplier arbiter slice.
package mgt_01_mul_arbiter_pkg;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 31;
  localparam int CNT_W   = 5;

  typedef enum logic {
    REQ_INT = 1'b0,
    REQ_FPU = 1'b1
  } req_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

  function automatic logic [1:0] req_onehot(input req_idx_e idx);
    return (idx == REQ_FPU) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mgt_01_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to ptr_i.
module mgt_01_rr_arbiter2
  import mgt_01_mul_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_idx_e   ptr_i,
  output logic [1:0] grant_o
);

  // One-hot grant decode
  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) begin
      grant_o = req_onehot(ptr_i);
    end
  end

endmodule

// File: rtl/mgt_01_mul_arbiter.sv
// Shares one multiplier between the INT unit and the FPU mantissa path.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | ready = grant; handshake latches operands/tag/owner
//   ST_ISSUE   | one-cycle start pulse to the multiplier
//   ST_WAIT    | wait for mul_valid_i, abort with error at TIMEOUT
//   ST_RESPOND | hold response to owner until its resp_ready_i
module mgt_01_mul_arbiter #(
  parameter int XLEN    = mgt_01_mul_arbiter_pkg::XLEN,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = mgt_01_mul_arbiter_pkg::TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0][XLEN-1:0]  req_a_i,
  input  logic [1:0][XLEN-1:0]  req_b_i,
  input  logic [1:0][TAG_W-1:0] req_tag_i,
  output logic [XLEN-1:0]       mul_a_o,
  output logic [XLEN-1:0]       mul_b_o,
  output logic                  mul_start_o,
  input  logic                  mul_valid_i,
  input  logic [2*XLEN-1:0]     mul_result_i,
  output logic [1:0]            resp_valid_o,
  input  logic [1:0]            resp_ready_i,
  output logic [2*XLEN-1:0]     resp_result_o,
  output logic [TAG_W-1:0]      resp_tag_o,
  output logic                  resp_err_o,
  output logic                  busy_o
);

  import mgt_01_mul_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_e              state_q, state_d;
  req_idx_e            ptr_q, ptr_d;
  req_idx_e            owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [2*XLEN-1:0]   result_q, result_d;
  logic                err_q, err_d;
  logic [1:0]          grant;

  mgt_01_rr_arbiter2 u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // State and datapath registers, synchronous reset clears everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      ptr_q    <= REQ_INT;
      owner_q  <= REQ_INT;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    tag_d    = tag_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          owner_d = grant[1] ? REQ_FPU : REQ_INT;
          a_d     = grant[1] ? req_a_i[1]   : req_a_i[0];
          b_d     = grant[1] ? req_b_i[1]   : req_b_i[0];
          tag_d   = grant[1] ? req_tag_i[1] : req_tag_i[0];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Counter holds the number of WAIT cycles including the current one
        cnt_d   = CNT_W'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_valid_i) begin
          result_d = mul_result_i;
          err_d    = 1'b0;
          state_d  = ST_RESPOND;
        end else if (cnt_q == TO_CNT) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESPOND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESPOND: begin
        if (resp_ready_i[owner_q]) begin
          ptr_d   = (owner_q == REQ_INT) ? REQ_FPU : REQ_INT;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready_o   = (state_q == ST_IDLE && !rst_i) ? grant : 2'b00;
  assign mul_start_o   = (state_q == ST_ISSUE);
  assign mul_a_o       = a_q;
  assign mul_b_o       = b_q;
  assign resp_valid_o  = (state_q == ST_RESPOND) ? req_onehot(owner_q) : 2'b00;
  assign resp_result_o = result_q;
  assign resp_tag_o    = tag_q;
  assign resp_err_o    = (state_q == ST_RESPOND) && err_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mgt_01_mul_arbiter.sv
// Directed bench with a response scoreboard and a behavioural multiplier.
module tb_mgt_01_mul_arbiter;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [1:0]            req_valid_i;
  logic [1:0]            req_ready_o;
  logic [1:0][XLEN-1:0]  req_a_i;
  logic [1:0][XLEN-1:0]  req_b_i;
  logic [1:0][TAG_W-1:0] req_tag_i;
  logic [XLEN-1:0]       mul_a_o, mul_b_o;
  logic                  mul_start_o;
  logic                  mul_valid_i;
  logic [2*XLEN-1:0]     mul_result_i;
  logic [1:0]            resp_valid_o;
  logic [1:0]            resp_ready_i;
  logic [2*XLEN-1:0]     resp_result_o;
  logic [TAG_W-1:0]      resp_tag_o;
  logic                  resp_err_o;
  logic                  busy_o;

  logic        mdl_valid, stray_valid;
  logic [63:0] mdl_res, stray_res;
  int          mul_lat = 1;
  bit          mul_en  = 1'b1;

  assign mul_valid_i  = mdl_valid | stray_valid;
  assign mul_result_i = stray_valid ? stray_res : mdl_res;

  typedef struct {
    int          owner;
    logic [63:0] result;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk_i = ~clk_i;

  mgt_01_mul_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_a_i       (req_a_i),
    .req_b_i       (req_b_i),
    .req_tag_i     (req_tag_i),
    .mul_a_o       (mul_a_o),
    .mul_b_o       (mul_b_o),
    .mul_start_o   (mul_start_o),
    .mul_valid_i   (mul_valid_i),
    .mul_result_i  (mul_result_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_result_o (resp_result_o),
    .resp_tag_o    (resp_tag_o),
    .resp_err_o    (resp_err_o),
    .busy_o        (busy_o)
  );

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  // Behavioural multiplier: done pulse mul_lat cycles after the start pulse
  initial begin
    logic [31:0] ma, mb;
    mdl_valid = 1'b0;
    mdl_res   = '0;
    forever begin
      @(posedge clk_i); #1;
      if (mul_start_o && mul_en) begin
        ma = mul_a_o;
        mb = mul_b_o;
        repeat (mul_lat) @(posedge clk_i);
        #1;
        mdl_res   = prod(ma, mb);
        mdl_valid = 1'b1;
        @(posedge clk_i); #1;
        mdl_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Called just after a negedge; the handshake happens at the following posedge
  task automatic accept(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [1:0] exp_ready,
                        input bit push, input bit err);
    exp_t e;
    req_valid_i[r] = 1'b1;
    req_a_i[r]     = a;
    req_b_i[r]     = b;
    req_tag_i[r]   = tag;
    #1;
    chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
    if (push) begin
      e.owner  = r;
      e.result = err ? 64'd0 : prod(a, b);
      e.tag    = tag;
      e.err    = err;
      sb.push_back(e);
    end
    @(negedge clk_i);
    req_valid_i[r] = 1'b0;
    #1;
    chk("mul_start", 64'(mul_start_o), 64'd1);
    chk("mul_a", 64'(mul_a_o), 64'(a));
    chk("mul_b", 64'(mul_b_o), 64'(b));
    chk("issue_busy", 64'(busy_o), 64'd1);
    chk("issue_ready_zero", 64'(req_ready_o), 64'd0);
  endtask

  task automatic wait_resp(input int hold, input int exp_n);
    int          n;
    exp_t        e;
    logic [1:0]  v;
    logic [63:0] r;
    logic [4:0]  t;
    n = 0;
    while (resp_valid_o == 2'b00 && n < 100) begin
      @(negedge clk_i); #1;
      n++;
    end
    chk("resp_latency", 64'(n), 64'(exp_n));
    if (resp_valid_o == 2'b00) return;
    chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("resp_valid", 64'(resp_valid_o), (e.owner == 1) ? 64'd2 : 64'd1);
    chk("resp_result", resp_result_o, e.result);
    chk("resp_tag", 64'(resp_tag_o), 64'(e.tag));
    chk("resp_err", 64'(resp_err_o), 64'(e.err));
    v = resp_valid_o;
    r = resp_result_o;
    t = resp_tag_o;
    repeat (hold) begin
      @(negedge clk_i); #1;
      chk("hold_valid", 64'(resp_valid_o), 64'(v));
      chk("hold_result", resp_result_o, r);
      chk("hold_tag", 64'(resp_tag_o), 64'(t));
      chk("hold_req_ready", 64'(req_ready_o), 64'd0);
    end
    resp_ready_i = resp_valid_o;
    @(negedge clk_i);
    resp_ready_i = 2'b00;
    #1;
    chk("resp_done_valid", 64'(resp_valid_o), 64'd0);
    chk("resp_done_busy", 64'(busy_o), 64'd0);
  endtask

  task automatic check_idle_zero();
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_mul_start", 64'(mul_start_o), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_resp_err", 64'(resp_err_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_mul_a", 64'(mul_a_o), 64'd0);
    chk("rst_mul_b", 64'(mul_b_o), 64'd0);
    chk("rst_resp_result", resp_result_o, 64'd0);
    chk("rst_resp_tag", 64'(resp_tag_o), 64'd0);
  endtask

  initial begin
    bit seen;
    rst_i        = 1'b1;
    req_valid_i  = 2'b11;
    req_a_i      = '0;
    req_b_i      = '0;
    req_tag_i    = '0;
    resp_ready_i = 2'b00;
    stray_valid  = 1'b0;
    stray_res    = '0;

    // Reset with requests pending: nothing may be granted
    repeat (2) @(negedge clk_i);
    #1;
    check_idle_zero();
    rst_i       = 1'b0;
    req_valid_i = 2'b00;

    // Single INT request, 7 * -3
    @(negedge clk_i);
    accept(0, 32'd7, 32'hFFFF_FFFD, 5'd4, 2'b01, 1'b0, 1'b0);
    sb.push_back('{owner: 0, result: 64'hFFFF_FFFF_FFFF_FFEB, tag: 5'd4, err: 1'b0});
    wait_resp(0, 2);

    // Fresh reset so the pointer starts at INT
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_idle_zero();

    // Simultaneous pairs: INT, then FPU, then INT again
    @(negedge clk_i);
    req_valid_i[1] = 1'b1;
    req_a_i[1]     = 32'hFFFE_7960;   // -100000
    req_b_i[1]     = 32'd300000;
    req_tag_i[1]   = 5'd2;
    accept(0, 32'd100, 32'd200, 5'd1, 2'b01, 1'b1, 1'b0);
    wait_resp(0, 2);
    chk("b2b_ready_fpu", 64'(req_ready_o), 64'd2);
    accept(1, 32'hFFFE_7960, 32'd300000, 5'd2, 2'b10, 1'b1, 1'b0);
    wait_resp(0, 2);
    req_valid_i[1] = 1'b1;
    req_a_i[1]     = 32'd65536;
    req_b_i[1]     = 32'd65536;
    req_tag_i[1]   = 5'd5;
    accept(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 2'b01, 1'b1, 1'b0);
    wait_resp(0, 2);
    accept(1, 32'd65536, 32'd65536, 5'd5, 2'b10, 1'b1, 1'b0);
    wait_resp(0, 2);

    // Response back-pressure for 10 cycles while a new request stalls
    @(negedge clk_i);
    accept(0, 32'hFFFF_FFFB, 32'd9, 5'd17, 2'b01, 1'b1, 1'b0);
    req_valid_i[1] = 1'b1;
    req_a_i[1]     = 32'h1234_5678;
    req_b_i[1]     = 32'd3;
    req_tag_i[1]   = 5'd30;
    wait_resp(10, 2);
    accept(1, 32'h1234_5678, 32'd3, 5'd30, 2'b10, 1'b1, 1'b0);
    wait_resp(0, 2);

    // Stray done pulse in IDLE, then a multiplier that never answers
    mul_en = 1'b0;
    @(negedge clk_i);
    stray_valid = 1'b1;
    stray_res   = 64'd123;
    @(negedge clk_i);
    stray_valid = 1'b0;
    #1;
    chk("stray_busy", 64'(busy_o), 64'd0);
    chk("stray_resp_valid", 64'(resp_valid_o), 64'd0);
    @(negedge clk_i);
    accept(0, 32'd3, 32'd4, 5'd9, 2'b01, 1'b1, 1'b1);
    wait_resp(0, 32);
    mul_en = 1'b1;

    // Reset during WAIT: abort silently, late done pulse ignored
    mul_lat = 10;
    @(negedge clk_i);
    accept(0, 32'd11, 32'd13, 5'd6, 2'b01, 1'b0, 1'b0);
    repeat (2) @(negedge clk_i);
    #1;
    chk("wait_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check_idle_zero();
    rst_i = 1'b0;
    seen  = 1'b0;
    repeat (20) begin
      @(negedge clk_i); #1;
      if (resp_valid_o != 2'b00 || busy_o) seen = 1'b1;
    end
    chk("late_resp_ignored", 64'(seen), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
